// File: rtl/bpb_update_sched_pkg.sv
// Shared types for the BPB commit-side update scheduler: machine word, BPB
// result {taken, destpc}, queued update entry and default sizing.
package bpb_update_sched_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      logic  taken;
      word_t destpc;
   } bpb_result_t;

   typedef struct packed {
      word_t       pc;
      bpb_result_t res;
   } bpb_upd_entry_t;

   localparam int BPB_UPD_DEPTH = 4;

   localparam bpb_upd_entry_t BPB_UPD_ENTRY_NULL = '{
      pc:  32'h0000_0000,
      res: '{taken: 1'b0, destpc: 32'h0000_0000}
   };

   // Number of set bits in a two-lane valid mask (0, 1 or 2).
   function automatic logic [1:0] lane_cnt(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/bpb_update_sched_if.sv
// Commit-to-BPB update bus: dual-lane resolved-branch commits in, single BPB
// write port out. master = commit stage / BPB side, slave = scheduler.
interface bpb_update_sched_if;
   import bpb_update_sched_pkg::*;

   logic              [1:0] commit_valid;
   word_t             [1:0] commit_pc;
   bpb_result_t       [1:0] commit_result;
   logic                    upd_wen;
   word_t                   upd_pc;
   bpb_result_t             upd_result;

   modport master (
      output commit_valid, commit_pc, commit_result,
      input  upd_wen, upd_pc, upd_result
   );

   modport slave (
      input  commit_valid, commit_pc, commit_result,
      output upd_wen, upd_pc, upd_result
   );
endinterface

// File: rtl/bpb_update_sched_fifo.sv
// bpb_upd_fifo: circular DEPTH-entry FIFO with 0-2 in-order pushes and one pop
// per cycle. Push lanes are compacted so a lone lane 1 takes the tail slot.
// The caller guarantees it never pushes beyond free space nor pops when empty.
module bpb_upd_fifo
   import bpb_update_sched_pkg::*;
#(
   parameter int DEPTH = BPB_UPD_DEPTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic           [1:0]        push_i,
   input  bpb_upd_entry_t [1:0]        push_data_i,
   input  logic                        pop_i,
   output bpb_upd_entry_t              head_o,
   output logic [$clog2(DEPTH):0]      count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]  head_q, head_d, tail_q, tail_d, tail1_s;
   logic [CW-1:0]  count_q, count_d;
   logic [1:0]     n_push_s;
   bpb_upd_entry_t first_s;
   bpb_upd_entry_t mem_q [DEPTH];

   // Compact the push lanes and compute next pointers and occupancy.
   always_comb begin
      n_push_s = lane_cnt(push_i);
      if (push_i[0]) begin
         first_s = push_data_i[0];
      end else begin
         first_s = push_data_i[1];
      end
      tail1_s = tail_q + AW'(1'b1);
      tail_d  = tail_q + AW'(n_push_s);
      head_d  = head_q + AW'(pop_i);
      count_d = count_q + CW'(n_push_s) - CW'(pop_i);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= {AW{1'b0}};
         tail_q  <= {AW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage: first compacted entry at tail, lane 1 behind it on a dual push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= BPB_UPD_ENTRY_NULL;
         end
      end else begin
         if (n_push_s != 2'd0) begin
            mem_q[tail_q] <= first_s;
         end
         if (push_i == 2'b11) begin
            mem_q[tail1_s] <= push_data_i[1];
         end
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/bpb_update_sched.sv
// bpb_update_sched: queues up to two resolved-branch commits per cycle and
// drains one BPB update per cycle. No backpressure: overflow lanes are dropped
// newest-first and counted in a saturating counter.
// Optional build macro BPB_UPD_BYPASS_EN: with an empty FIFO and no stall the
// oldest valid lane is written to the BPB in the same cycle.
module bpb_update_sched
   import bpb_update_sched_pkg::*;
#(
   parameter int DEPTH  = BPB_UPD_DEPTH,
   parameter int DROP_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_i,
   bpb_update_sched_if.slave  bus,
   output logic               pending_o,
   output logic [DROP_W-1:0]  drop_cnt_o
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]           count_s, free_s;
   logic                    nonempty_s, pop_s, bypass_s;
   logic [1:0]              accept_s, push_s, drop_n_s;
   bpb_upd_entry_t          head_s, out_s;
   bpb_upd_entry_t [1:0]    lane_data_s;
   logic [DROP_W:0]         drop_sum_s;
   logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d;

   assign lane_data_s[0] = '{pc: bus.commit_pc[0], res: bus.commit_result[0]};
   assign lane_data_s[1] = '{pc: bus.commit_pc[1], res: bus.commit_result[1]};

   assign nonempty_s = (count_s != {CW{1'b0}});
   assign pop_s      = nonempty_s & ~stall_i;
   // Space freed by this cycle's pop is usable by this cycle's commits.
   assign free_s     = CW'(DEPTH) - count_s + CW'(pop_s);

`ifdef BPB_UPD_BYPASS_EN
   assign bypass_s = ~nonempty_s & ~stall_i & (|bus.commit_valid);
`else
   assign bypass_s = 1'b0;
`endif

   // Accept the oldest valid lanes that fit; the rest are dropped newest-first.
   always_comb begin
      accept_s = 2'b00;
      if (free_s >= CW'(2'd2)) begin
         accept_s = bus.commit_valid;
      end else if (free_s == CW'(2'd1)) begin
         if (bus.commit_valid[0]) begin
            accept_s = 2'b01;
         end else begin
            accept_s = bus.commit_valid & 2'b10;
         end
      end else begin
         accept_s = 2'b00;
      end
   end

   // A bypassed lane goes straight to the BPB, so it is withheld from the FIFO.
   always_comb begin
      push_s = accept_s;
      if (bypass_s) begin
         if (bus.commit_valid[0]) begin
            push_s = accept_s & 2'b10;
         end else begin
            push_s = 2'b00;
         end
      end else begin
         push_s = accept_s;
      end
   end

   bpb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_s),
      .push_data_i (lane_data_s),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .count_o     (count_s)
   );

   // BPB write port: bypass lane, else FIFO head, else all zeros.
   always_comb begin
      out_s = BPB_UPD_ENTRY_NULL;
      if (bypass_s) begin
         if (bus.commit_valid[0]) begin
            out_s = lane_data_s[0];
         end else begin
            out_s = lane_data_s[1];
         end
      end else if (nonempty_s) begin
         out_s = head_s;
      end else begin
         out_s = BPB_UPD_ENTRY_NULL;
      end
      bus.upd_wen    = pop_s | bypass_s;
      bus.upd_pc     = out_s.pc;
      bus.upd_result = out_s.res;
   end

   // Saturating add of this cycle's dropped lanes.
   always_comb begin
      drop_n_s   = lane_cnt(bus.commit_valid) - lane_cnt(accept_s);
      drop_sum_s = {1'b0, drop_cnt_q} + (DROP_W + 1)'(drop_n_s);
      if (drop_sum_s[DROP_W]) begin
         drop_cnt_d = {DROP_W{1'b1}};
      end else begin
         drop_cnt_d = drop_sum_s[DROP_W-1:0];
      end
   end

   // Drop counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= {DROP_W{1'b0}};
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign pending_o  = nonempty_s;
   assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bpb_update_sched.sv
// Directed self-checking bench for bpb_update_sched (DEPTH 4, DROP_W 16).
// Expectations follow the default build, with BPB_UPD_BYPASS_EN variants
// where an empty, unstalled FIFO sees a commit.
module tb_bpb_update_sched;
   import bpb_update_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        pending;
   logic [15:0] drop_cnt;
   int          n_checks = 0;
   int          n_fails  = 0;

   word_t       cpc  [12];
   bpb_result_t cres [12];

   localparam word_t       PC1 = 32'h8000_0010;
   localparam bpb_result_t R1  = '{taken: 1'b1, destpc: 32'h8000_0100};
   localparam word_t       PCA = 32'h8000_0020;
   localparam bpb_result_t RA  = '{taken: 1'b0, destpc: 32'h8000_0024};
   localparam word_t       PCB = 32'h8000_0030;
   localparam bpb_result_t RB  = '{taken: 1'b1, destpc: 32'h8000_0200};
   localparam word_t       PCE = 32'h8000_0040;
   localparam bpb_result_t RE  = '{taken: 1'b1, destpc: 32'h8000_0444};
   localparam bpb_result_t RZ  = '{taken: 1'b0, destpc: 32'h0000_0000};

   bpb_update_sched_if bus_if ();

   bpb_update_sched #(.DEPTH(4), .DROP_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall_i    (stall),
      .bus        (bus_if),
      .pending_o  (pending),
      .drop_cnt_o (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input string tag, input word_t pc, input bpb_result_t res);
      check_eq($sformatf("%s_wen", tag), {63'd0, bus_if.upd_wen}, 64'd1);
      check_eq($sformatf("%s_pc", tag), {32'd0, bus_if.upd_pc}, {32'd0, pc});
      check_eq($sformatf("%s_res", tag), {31'd0, bus_if.upd_result}, {31'd0, res});
   endtask

   task automatic check_idle_wen(input string tag);
      check_eq(tag, {63'd0, bus_if.upd_wen}, 64'd0);
   endtask

   task automatic drive(input logic [1:0] v, input word_t p0, input bpb_result_t r0,
                        input word_t p1, input bpb_result_t r1, input logic st);
      bus_if.commit_valid     = v;
      bus_if.commit_pc[0]     = p0;
      bus_if.commit_result[0] = r0;
      bus_if.commit_pc[1]     = p1;
      bus_if.commit_result[1] = r1;
      stall                   = st;
      #1;
   endtask

   task automatic idle(input logic st);
      drive(2'b00, 32'h0, RZ, 32'h0, RZ, st);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic word_t wpc(input int i);
      return 32'h7000_0000 + (word_t'(i) << 4);
   endfunction

   function automatic bpb_result_t wres(input int i);
      return '{taken: i[0], destpc: wpc(i) + 32'h0000_0008};
   endfunction

   initial begin
      for (int i = 0; i < 12; i++) begin
         cpc[i]  = 32'h9000_0000 + (word_t'(i) << 2);
         cres[i] = '{taken: i[0], destpc: 32'hA000_0000 + word_t'(i)};
      end

      // Reset state
      reset = 1'b1;
      idle(1'b0);
      tick();
      check_idle_wen("rst_wen");
      check_eq("rst_pc", {32'd0, bus_if.upd_pc}, 64'd0);
      check_eq("rst_res", {31'd0, bus_if.upd_result}, 64'd0);
      check_eq("rst_pending", {63'd0, pending}, 64'd0);
      check_eq("rst_drop", {48'd0, drop_cnt}, 64'd0);
      tick();
      reset = 1'b0;
      tick();

      // Single lane-0 commit
      drive(2'b01, PC1, R1, 32'h0, RZ, 1'b0);
`ifdef BPB_UPD_BYPASS_EN
      check_wr("t1_same", PC1, R1);
`else
      check_idle_wen("t1_wen_c0");
`endif
      tick(); idle(1'b0);
`ifdef BPB_UPD_BYPASS_EN
      check_idle_wen("t1_wen_c1");
`else
      check_wr("t1_next", PC1, R1);
      check_eq("t1_pending", {63'd0, pending}, 64'd1);
`endif
      tick(); idle(1'b0);
      check_eq("t1_pending_lo", {63'd0, pending}, 64'd0);
      check_idle_wen("t1_wen_c2");
      check_eq("t1_pc_empty", {32'd0, bus_if.upd_pc}, 64'd0);

      // Dual commit, A then B
      drive(2'b11, PCA, RA, PCB, RB, 1'b0);
`ifdef BPB_UPD_BYPASS_EN
      check_wr("t2_c0", PCA, RA);
`else
      check_idle_wen("t2_c0_wen");
`endif
      tick(); idle(1'b0);
`ifdef BPB_UPD_BYPASS_EN
      check_wr("t2_c1", PCB, RB);
`else
      check_wr("t2_c1", PCA, RA);
`endif
      tick(); idle(1'b0);
`ifdef BPB_UPD_BYPASS_EN
      check_idle_wen("t2_c2_wen");
`else
      check_wr("t2_c2", PCB, RB);
`endif
      tick(); idle(1'b0);
      check_idle_wen("t2_c3_wen");
      check_eq("t2_drop", {48'd0, drop_cnt}, 64'd0);

      // Stall held 6 cycles, three dual commits: 4 queued, third pair dropped
      drive(2'b11, cpc[0], cres[0], cpc[1], cres[1], 1'b1);
      check_idle_wen("t3_stall_wen");
      tick();
      drive(2'b11, cpc[2], cres[2], cpc[3], cres[3], 1'b1);
      tick();
      drive(2'b11, cpc[4], cres[4], cpc[5], cres[5], 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         check_eq("t3_drop", {48'd0, drop_cnt}, 64'd2);
         check_eq("t3_pending", {63'd0, pending}, 64'd1);
         check_idle_wen("t3_hold_wen");
         check_eq("t3_head_pc", {32'd0, bus_if.upd_pc}, {32'd0, cpc[0]});
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         check_wr($sformatf("t3_drain%0d", i), cpc[i], cres[i]);
         tick();
      end
      idle(1'b0);
      check_idle_wen("t3_empty_wen");
      check_eq("t3_drop_end", {48'd0, drop_cnt}, 64'd2);

      // Full FIFO, no stall, dual commit: lane 0 accepted, lane 1 dropped
      drive(2'b11, cpc[6], cres[6], cpc[7], cres[7], 1'b1);
      tick();
      drive(2'b11, cpc[8], cres[8], cpc[9], cres[9], 1'b1);
      tick();
      drive(2'b11, cpc[10], cres[10], cpc[11], cres[11], 1'b0);
      check_wr("t4_pop", cpc[6], cres[6]);
      tick();
      for (int i = 7; i <= 10; i++) begin
         idle(1'b0);
         if (i == 7) begin
            check_eq("t4_drop", {48'd0, drop_cnt}, 64'd3);
         end
         check_wr($sformatf("t4_drain%0d", i), cpc[i], cres[i]);
         tick();
      end
      idle(1'b0);
      check_idle_wen("t4_empty_wen");
      check_eq("t4_pending_lo", {63'd0, pending}, 64'd0);

      // Lane 1 alone takes the first free slot
      drive(2'b10, 32'h0, RZ, PCE, RE, 1'b0);
`ifdef BPB_UPD_BYPASS_EN
      check_wr("t6_c0", PCE, RE);
`else
      check_idle_wen("t6_c0_wen");
`endif
      tick(); idle(1'b0);
`ifdef BPB_UPD_BYPASS_EN
      check_idle_wen("t6_c1_wen");
`else
      check_wr("t6_c1", PCE, RE);
`endif
      tick();

      // Pointer wrap: 10 single commits back to back
      for (int i = 0; i <= 10; i++) begin
         if (i < 10) begin
            drive(2'b01, wpc(i), wres(i), 32'h0, RZ, 1'b0);
         end else begin
            idle(1'b0);
         end
`ifdef BPB_UPD_BYPASS_EN
         if (i < 10) begin
            check_wr($sformatf("t5_w%0d", i), wpc(i), wres(i));
         end else begin
            check_idle_wen("t5_tail_wen");
         end
`else
         if (i > 0) begin
            check_wr($sformatf("t5_w%0d", i - 1), wpc(i - 1), wres(i - 1));
         end else begin
            check_idle_wen("t5_first_wen");
         end
`endif
         tick();
      end
      idle(1'b0);
      check_idle_wen("t5_end_wen");
      check_eq("t5_drop", {48'd0, drop_cnt}, 64'd3);

      // Asynchronous reset discards pending updates immediately
      drive(2'b11, cpc[0], cres[0], cpc[1], cres[1], 1'b1);
      tick();
      idle(1'b1);
      check_eq("t7_pending_pre", {63'd0, pending}, 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check_eq("t7_pending_rst", {63'd0, pending}, 64'd0);
      check_eq("t7_drop_rst", {48'd0, drop_cnt}, 64'd0);
      check_eq("t7_pc_rst", {32'd0, bus_if.upd_pc}, 64'd0);
      tick();
      reset = 1'b0;
      idle(1'b0);
      tick();
      idle(1'b0);
      check_idle_wen("t7_wen_after");
      check_eq("t7_pending_after", {63'd0, pending}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
